mux_scan_ctrl: RTL and testbench

Scan controller that drives the 3-bit select of the 8:1 priority-case bit mux and captures the bit returned for each channel into a word. It walks the channels enabled by a mask, lowest index first, and presents the result on a valid/ready output port. It sits between the channel mux (it owns `io_sel` and consumes `io_out`) and the byte-wide consumer stage.

---
 rtl/mux_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//
// Walks the channels enabled by a mask through an 8:1 bit mux, lowest index
// first. It drives the mux select, waits SETTLE_CYCLES extra cycles per
// channel, then samples the returned bit into a result word. The finished word
// is offered on a valid/ready output port.
//
// Parameters:
//   SETTLE_CYCLES  extra wait cycles between a new select and its sample (0..3)
//
// Ports:
//   clock          single clock
//   reset          synchronous, active-high reset
//   io_start       start-scan pulse, accepted only while idle
//   io_mask        channel enables, captured on an accepted start
//   io_sel         channel select to the mux (0 when not scanning)
//   io_bit         mux output for the channel on io_sel
//   io_busy        high whenever the controller is not idle
//   io_out_valid   result word available
//   io_out_ready   consumer accepts the result
//   io_out_bits    bit i = sample of channel i, 0 for masked-off channels
//   io_out_count   number of channels sampled (0..8)
//   dbg_state_o    current FSM state (0 idle, 1 scan, 2 hold)
//
// Output handshake: a result transfers on every rising clock edge where
// io_out_valid and io_out_ready are both high. Once io_out_valid is raised,
// it and the result fields stay unchanged until that transfer happens.
// io_out_ready may be driven freely and has no combinational path to any
// output.

module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_start,
    input  logic [7:0] io_mask,
    output logic [2:0] io_sel,
    input  logic       io_bit,
    output logic       io_busy,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [7:0] io_out_bits,
    output logic [3:0] io_out_count,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] bits_q, bits_d;
    logic [3:0] count_q, count_d;

    logic [2:0] low_idx;
    logic [7:0] pend_after;

    // Lowest set bit of the pending mask; scanning downward lets the lowest
    // index win. Once a channel is sampled its bit is cleared, so the next
    // enabled channel is selected on the very next cycle with no dead cycle.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign pend_after = pend_q & ~(8'd1 << low_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 8'd0;
            cnt_q   <= 2'd0;
            bits_q  <= 8'd0;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                bits_d  = 8'd0;
                count_d = 4'd0;
                cnt_d   = 2'd0;
                if (io_start) begin
                    pend_d  = io_mask;
                    // An empty mask has nothing to sample: report at once.
                    state_d = (io_mask != 8'd0) ? ST_SCAN : ST_HOLD;
                end
            end
            ST_SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    bits_d[low_idx] = io_bit;
                    count_d         = count_q + 4'd1;
                    pend_d          = pend_after;
                    cnt_d           = 2'd0;
                    if (pend_after == 8'd0) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (io_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_sel       = (state_q == ST_SCAN) ? low_idx : 3'd0;
    assign io_busy      = (state_q != ST_IDLE);
    assign io_out_valid = (state_q == ST_HOLD);
    assign io_out_bits  = bits_q;
    assign io_out_count = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 0 and settle 2) share clock
// and reset and are exercised one at a time. The driver computes each scan's
// expected result from the mask, the mux inputs and the sampling schedule and
// pushes it into exp_q; the monitor pops and compares on every handshake.

module tb_mux_scan_ctrl;

    localparam int NDUT = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Number of rising edges seen so far; in toggle mode the mux bit is the
    // parity of this count, so it flips every cycle.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       start   [NDUT];
    logic [7:0] mask    [NDUT];
    logic [2:0] sel     [NDUT];
    logic       busy    [NDUT];
    logic       valid   [NDUT];
    logic       ready   [NDUT];
    logic [7:0] bits    [NDUT];
    logic [3:0] count   [NDUT];
    logic [1:0] dbg     [NDUT];
    logic [7:0] mux_in  [NDUT];
    logic       tog     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 0 : 2;
        logic bit_w;
        assign bit_w = tog[g] ? cyc[0] : mux_in[g][sel[g]];
        mux_scan_ctrl #(.SETTLE_CYCLES(S)) u_dut (
            .clock        (clock),
            .reset        (reset),
            .io_start     (start[g]),
            .io_mask      (mask[g]),
            .io_sel       (sel[g]),
            .io_bit       (bit_w),
            .io_busy      (busy[g]),
            .io_out_valid (valid[g]),
            .io_out_ready (ready[g]),
            .io_out_bits  (bits[g]),
            .io_out_count (count[g]),
            .dbg_state_o  (dbg[g])
        );
    end

    function automatic int settle_of(int d);
        return (d == 0) ? 0 : 2;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard entry: {dut index, count[3:0], bits[7:0]}
    logic [12:0] exp_q[$];

    always @(negedge clock) begin
        logic [12:0] e;
        for (int g = 0; g < NDUT; g++) begin
            if (valid[g] && ready[g]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", g, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_dut", g, g, {31'd0, e[12]});
                    check("result_bits", g, {24'd0, bits[g]}, {24'd0, e[7:0]});
                    check("result_count", g, {28'd0, count[g]}, {28'd0, e[11:8]});
                end
            end
        end
    end

    task automatic noise(int d);
        start[d] = 1'($urandom_range(0, 1));
        mask[d]  = 8'($urandom);
    endtask

    task automatic run_scan(int d, logic [7:0] m, logic [7:0] in, logic tg,
                            int hold, logic nz);
        int s;
        int e_acc;
        int samp_e;
        int ch[$];
        logic [7:0] exp_bits;
        s = settle_of(d);
        exp_bits = 8'd0;
        check("idle_before_start", d, {31'd0, busy[d]}, 32'd0);
        mux_in[d] = in;
        tog[d]    = tg;
        mask[d]   = m;
        start[d]  = 1'b1;
        ready[d]  = (hold == 0);
        e_acc = cyc;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                samp_e = e_acc + (ch.size() + 1) * (s + 1);
                exp_bits[i] = tg ? samp_e[0] : in[i];
                ch.push_back(i);
            end
        end
        exp_q.push_back({d[0], 4'(ch.size()), exp_bits});
        step();
        start[d] = 1'b0;
        check("busy_after_start", d, {31'd0, busy[d]}, 32'd1);
        foreach (ch[c]) begin
            for (int k = 0; k <= s; k++) begin
                check("sel_scan", d, {29'd0, sel[d]}, ch[c]);
                if (nz) noise(d);
                step();
            end
        end
        check("valid_rise", d, {31'd0, valid[d]}, 32'd1);
        check("sel_hold", d, {29'd0, sel[d]}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", d, {31'd0, valid[d]}, 32'd1);
            check("hold_bits", d, {24'd0, bits[d]}, {24'd0, exp_bits});
            check("hold_count", d, {28'd0, count[d]}, ch.size());
            if (nz) noise(d);
            step();
        end
        ready[d] = 1'b1;
        // A start coincident with the handshake must be dropped.
        if (nz) begin
            start[d] = 1'b1;
            mask[d]  = 8'($urandom);
        end
        step();
        start[d] = 1'b0;
        ready[d] = 1'b0;
        check("idle_after_handshake", d, {31'd0, busy[d]}, 32'd0);
        check("valid_after_handshake", d, {31'd0, valid[d]}, 32'd0);
    endtask

    task automatic check_reset_values(int d);
        check("rst_sel", d, {29'd0, sel[d]}, 32'd0);
        check("rst_busy", d, {31'd0, busy[d]}, 32'd0);
        check("rst_valid", d, {31'd0, valid[d]}, 32'd0);
        check("rst_bits", d, {24'd0, bits[d]}, 32'd0);
        check("rst_count", d, {28'd0, count[d]}, 32'd0);
        check("rst_state", d, {30'd0, dbg[d]}, 32'd0);
    endtask

    task automatic abort_scan(int d, int run_cycles);
        mux_in[d] = 8'($urandom);
        tog[d]    = 1'b0;
        mask[d]   = 8'hFF;
        start[d]  = 1'b1;
        ready[d]  = 1'b1;
        step();
        start[d] = 1'b0;
        repeat (run_cycles) step();
        reset = 1'b1;
        step();
        check_reset_values(d);
        reset = 1'b0;
        ready[d] = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            start[g] = 1'b0; mask[g] = 8'd0; ready[g] = 1'b0;
            mux_in[g] = 8'd0; tog[g] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) step();
        for (int g = 0; g < NDUT; g++) check_reset_values(g);
        reset = 1'b0;
        step();

        // Directed cases
        run_scan(0, 8'hFF, 8'hA5, 1'b0, 0, 1'b0);
        run_scan(0, 8'h12, 8'hFF, 1'b0, 0, 1'b0);
        run_scan(0, 8'h00, 8'hFF, 1'b0, 0, 1'b0);
        run_scan(1, 8'h00, 8'hFF, 1'b0, 2, 1'b0);
        run_scan(1, 8'h81, 8'h80, 1'b0, 0, 1'b0);
        // Backpressure and ignored start/mask, then back-to-back start
        run_scan(0, 8'h5A, 8'h3C, 1'b0, 5, 1'b1);
        run_scan(0, 8'hC3, 8'hF0, 1'b0, 0, 1'b0);
        run_scan(1, 8'h66, 8'h0F, 1'b0, 5, 1'b1);
        // Reset mid-scan, then clean scans with no residue
        abort_scan(0, 4);
        run_scan(0, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
        abort_scan(1, 7);
        run_scan(1, 8'h24, 8'hFF, 1'b0, 1, 1'b0);
        // Toggling mux bit every cycle
        run_scan(0, 8'hFF, 8'h00, 1'b1, 0, 1'b0);
        run_scan(1, 8'hB7, 8'h00, 1'b1, 2, 1'b0);
        // Randomized
        for (int t = 0; t < 16; t++) begin
            run_scan($urandom_range(0, 1), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)));
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
        check("queue_drained", 0, exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
